note_tone_gen: RTL and testbench
================================

Name: note_tone_gen

Overview:
- Downstream consumer of the recorder/player's `note` output.
- Turns the current note code into a square-wave audio signal for the speaker/PWM pin.
- Re-articulates on every note change: inserts a short silent gap, then restarts the tone phase.
- Rest and invalid codes produce silence.

Parameters:
- WORD_SIZE, 8, width of the note code; must be ≥ 7.
- CLK_HZ, 100000000, system clock frequency; the package period table is computed for this value.
- GAP_CYCLES, 500000, silent cycles between two different notes; 0 disables the gap.
- CNT_W, 22, half-period counter width; must hold the largest table entry.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- note  in  WORD_SIZE  note code. Bits [3:0] = pitch class 1..12 (C..B); 0 = rest; 13..15 = invalid. Bits [6:4] = octave 0..7. Upper bits are ignored.
- mute  in  1  forces audio_out low; tone timing keeps running.
- audio_out  out  1  square wave.
- playing  out  1  high while in the TONE state.
- note_change  out  1  one-cycle pulse when a new note code is accepted.
- bad_note  out  1  one-cycle pulse when an accepted code has pitch class 13..15.

Behaviour:
- Single clock domain. Reset is synchronous and active-high. Reset dominates all other inputs.
- Reset values:
  - state = REST.
  - note_q = 0; counters = 0.
  - audio_out = 0, playing = 0, note_change = 0, bad_note = 0.
- Change detection:
  - note is compared each cycle against the registered note_q (upper bits ignored).
  - On a mismatch: note_q takes the new value at the next edge, and note_change pulses for that one cycle.
- Period:
  - half_period = BASE_HALF[pitch] >> octave.
  - The result is latched into hp_q when the note is accepted, so mid-tone input changes never alter the running period before detection.
- States:
  - REST: audio_out = 0. On an accepted valid note, go to GAP; if GAP_CYCLES = 0, go directly to TONE.
  - GAP: audio_out = 0. gap_cnt loads GAP_CYCLES-1 and counts down. At 0, go to TONE.
  - TONE:
    - Entry cycle: audio_out = 1, phase counter loads hp_q-1.
    - The counter decrements each cycle. At 0, audio_out toggles and the counter reloads hp_q-1.
    - Result: each level lasts exactly hp_q cycles.
- Transitions on an accepted change, from any state:
  - New code is rest or invalid: go to REST (audio_out 0 at the next edge).
  - New code is valid: go to GAP, restarting the gap count. This includes a change during GAP.
- Holding the same code never restarts the phase.
- mute gates only the output. playing, the state and the counters are unaffected.
- Reset asserted mid-tone: at the next edge everything returns to reset values. After release, the current note input is re-detected as a change because note_q = 0.

Optional Feature:
- Macro: NOTE_TONE_GEN_OCTAVE_SHIFT_EN.
- Defined:
  - Adds input port octave_shift [1:0] (signed: -2..+1).
  - Effective octave = clamp(note[6:4] + octave_shift, 0, 7).
  - A change of octave_shift counts as a note change: gap, then phase restart.
- Undefined:
  - The port is absent.
  - Effective octave = note[6:4].

Decomposition:
- Shared package note_tone_pkg, containing:
  - Pitch class constants: REST = 0, C = 1 … B = 12.
  - Field positions PITCH_LSB/MSB and OCT_LSB/MSB.
  - State typedef {REST, GAP, TONE}.
  - BASE_HALF[1..12] = round(CLK_HZ/(2·f_octave0)), with A = 1818182 and C = 3057805.
  - Function is_valid_pitch.
- One natural sub-module: tone_divider. It is the reloadable down-counter with toggle output, taking load, hp_q and enable.

Test Plan:
1. Reset with note = 0x4A (A4) held → after release: note_change at cycle 1, GAP of 500000 cycles, then audio_out toggles every 113636 cycles (440 Hz); playing = 1.
2. GAP_CYCLES = 0, note 0x41 (C4) → TONE on the cycle after acceptance; half-period = 3057805 >> 4 = 191112 cycles.
3. Mid-tone change 0x4A → 0x5A (A5) → GAP with audio_out 0, then half-period 56818; note 0x00 → REST within 1 cycle, playing = 0.
4. Note 0x4E (pitch 14) → bad_note pulses once, state REST, audio_out stays 0; hold for 10 cycles → no further pulses.
5. mute = 1 during TONE → audio_out 0, playing stays 1; release mute → waveform resumes in original phase (counter not reset).
6. Reset asserted mid-GAP and mid-TONE → all outputs 0 at the next edge. With NOTE_TONE_GEN_OCTAVE_SHIFT_EN: 0x7A with shift +1 clamps to octave 7 (half-period 14204); shift -2 gives octave 5 (56818).

Source files
------------

// File: rtl/note_tone_gen_pkg.sv
// Shared definitions for the note tone generator: note field layout, pitch codes,
// FSM state type and the octave-0 half-period table (100 MHz reference clock).
package note_tone_pkg;

  localparam int PITCH_LSB = 0;
  localparam int PITCH_MSB = 3;
  localparam int OCT_LSB   = 4;
  localparam int OCT_MSB   = 6;
  localparam int BASE_W    = 22;

  localparam longint TABLE_CLK_HZ = 64'sd100_000_000;

  localparam logic [3:0] PC_REST = 4'd0;
  localparam logic [3:0] PC_C    = 4'd1;
  localparam logic [3:0] PC_CS   = 4'd2;
  localparam logic [3:0] PC_D    = 4'd3;
  localparam logic [3:0] PC_DS   = 4'd4;
  localparam logic [3:0] PC_E    = 4'd5;
  localparam logic [3:0] PC_F    = 4'd6;
  localparam logic [3:0] PC_FS   = 4'd7;
  localparam logic [3:0] PC_G    = 4'd8;
  localparam logic [3:0] PC_GS   = 4'd9;
  localparam logic [3:0] PC_A    = 4'd10;
  localparam logic [3:0] PC_AS   = 4'd11;
  localparam logic [3:0] PC_B    = 4'd12;

  typedef enum logic [1:0] {
    ST_REST = 2'd0,
    ST_GAP  = 2'd1,
    ST_TONE = 2'd2
  } tone_state_e;

  function automatic logic is_valid_pitch(input logic [3:0] pitch);
    return (pitch >= PC_C) && (pitch <= PC_B);
  endfunction

  function automatic logic is_bad_pitch(input logic [3:0] pitch);
    return pitch > PC_B;
  endfunction

  // Octave-0 half periods in 100 MHz cycles, round(1e8 / (2 * f)).
  function automatic logic [BASE_W-1:0] base_half(input logic [3:0] pitch);
    logic [BASE_W-1:0] half;
    case (pitch)
      PC_C:    half = 22'd3057805;
      PC_CS:   half = 22'd2886184;
      PC_D:    half = 22'd2724195;
      PC_DS:   half = 22'd2571297;
      PC_E:    half = 22'd2426982;
      PC_F:    half = 22'd2290766;
      PC_FS:   half = 22'd2162195;
      PC_G:    half = 22'd2040840;
      PC_GS:   half = 22'd1926297;
      PC_A:    half = 22'd1818182;
      PC_AS:   half = 22'd1716135;
      PC_B:    half = 22'd1619816;
      default: half = 22'd0;
    endcase
    return half;
  endfunction

  function automatic longint scale_half(input logic [BASE_W-1:0] base, input longint clk_hz);
    return (longint'(base) * clk_hz + TABLE_CLK_HZ / 64'sd2) / TABLE_CLK_HZ;
  endfunction

endpackage

// File: rtl/note_tone_gen_tone_divider.sv
// Reloadable half-period down-counter with toggling square-wave output.
module tone_divider
  import note_tone_pkg::*;
#(
  parameter int CNT_W = 22
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] hp_i,
  output logic             wave_next_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wave_q, wave_d;

  always_comb begin
    cnt_d  = '0;
    wave_d = 1'b0;
    if (load_i) begin
      cnt_d  = hp_i - CNT_W'(1);
      wave_d = 1'b1;
    end else if (enable_i) begin
      if (cnt_q == '0) begin
        cnt_d  = hp_i - CNT_W'(1);
        wave_d = ~wave_q;
      end else begin
        cnt_d  = cnt_q - CNT_W'(1);
        wave_d = wave_q;
      end
    end else begin
      cnt_d  = '0;
      wave_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      wave_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wave_q <= wave_d;
    end
  end

  // The top registers the mute-gated copy, so it needs the next level.
  assign wave_next_o = wave_d;

endmodule

// File: rtl/note_tone_gen.sv
// Note code to square-wave generator with a silent gap on every note change.
// Optional octave_shift input is enabled by defining NOTE_TONE_GEN_OCTAVE_SHIFT_EN.
module note_tone_gen
  import note_tone_pkg::*;
#(
  parameter int WORD_SIZE  = 8,
  parameter int CLK_HZ     = 100000000,
  parameter int GAP_CYCLES = 500000,
  parameter int CNT_W      = 22
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] note,
`ifdef NOTE_TONE_GEN_OCTAVE_SHIFT_EN
  input  logic [1:0]           octave_shift,
`endif
  input  logic                 mute,
  output logic                 audio_out,
  output logic                 playing,
  output logic                 note_change,
  output logic                 bad_note
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  tone_state_e      state_q, state_d;
  logic [6:0]       note_q;
  logic [CNT_W-1:0] hp_q;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             audio_q, playing_q, note_change_q, bad_note_q;

  logic [3:0]       pitch_s;
  logic [2:0]       oct_s;
  logic             change_s;
  logic [CNT_W-1:0] hp_new_s, hp_sel_s;
  logic             load_s, en_s, wave_next_s;
  logic [CNT_W-1:0] half_tab_s [16];

  // Per-pitch octave-0 half periods rescaled to CLK_HZ; constant after elaboration.
  for (genvar p = 0; p < 16; p++) begin : g_tab
    assign half_tab_s[p] = CNT_W'(scale_half(base_half(4'(p)), longint'(CLK_HZ)));
  end

  if (WORD_SIZE > 7) begin : g_upper
    logic unused_upper_s;
    assign unused_upper_s = ^note[WORD_SIZE-1:7];
  end

  assign pitch_s = note[PITCH_MSB:PITCH_LSB];

`ifdef NOTE_TONE_GEN_OCTAVE_SHIFT_EN
  logic [1:0]        shift_q;
  logic signed [4:0] oct_sum_s;

  always_comb begin
    oct_sum_s = $signed({2'b00, note[OCT_MSB:OCT_LSB]}) + $signed({{3{octave_shift[1]}}, octave_shift});
    if (oct_sum_s < 5'sd0) begin
      oct_s = 3'd0;
    end else if (oct_sum_s > 5'sd7) begin
      oct_s = 3'd7;
    end else begin
      oct_s = oct_sum_s[2:0];
    end
    change_s = (note[6:0] != note_q) || (octave_shift != shift_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= 2'b00;
    end else if (change_s) begin
      shift_q <= octave_shift;
    end else begin
      shift_q <= shift_q;
    end
  end
`else
  always_comb begin
    oct_s    = note[OCT_MSB:OCT_LSB];
    change_s = (note[6:0] != note_q);
  end
`endif

  assign hp_new_s = half_tab_s[pitch_s] >> oct_s;
  // With no gap the tone starts on the accept edge, before hp_q holds the new period.
  assign hp_sel_s = change_s ? hp_new_s : hp_q;

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    load_s  = 1'b0;
    en_s    = 1'b0;
    if (change_s) begin
      if (is_valid_pitch(pitch_s)) begin
        if (GAP_CYCLES == 0) begin
          state_d = ST_TONE;
          load_s  = 1'b1;
        end else begin
          state_d = ST_GAP;
          gap_d   = GAP_LOAD;
        end
      end else begin
        state_d = ST_REST;
      end
    end else begin
      case (state_q)
        ST_REST: state_d = ST_REST;
        ST_GAP: begin
          if (gap_q == '0) begin
            state_d = ST_TONE;
            load_s  = 1'b1;
          end else begin
            gap_d = gap_q - GAP_W'(1);
          end
        end
        ST_TONE: en_s = 1'b1;
        default: state_d = ST_REST;
      endcase
    end
  end

  tone_divider #(
    .CNT_W(CNT_W)
  ) u_div (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load_s),
    .enable_i   (en_s),
    .hp_i       (hp_sel_s),
    .wave_next_o(wave_next_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_REST;
      note_q        <= 7'd0;
      hp_q          <= '0;
      gap_q         <= '0;
      audio_q       <= 1'b0;
      playing_q     <= 1'b0;
      note_change_q <= 1'b0;
      bad_note_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      if (change_s) begin
        note_q <= note[6:0];
        hp_q   <= hp_new_s;
      end
      note_change_q <= change_s;
      bad_note_q    <= change_s && is_bad_pitch(pitch_s);
      playing_q     <= (state_d == ST_TONE);
      audio_q       <= wave_next_s & ~mute;
    end
  end

  assign audio_out   = audio_q;
  assign playing     = playing_q;
  assign note_change = note_change_q;
  assign bad_note    = bad_note_q;

endmodule

// File: tb/tb_note_tone_gen.sv
// Bench for note_tone_gen: a short-gap instance and a zero-gap instance.
module tb_note_tone_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] note_g, note_z;
  logic       mute_g, mute_z;
  logic       audio_g, play_g, chg_g, bad_g;
  logic       audio_z, play_z, chg_z, bad_z;
`ifdef NOTE_TONE_GEN_OCTAVE_SHIFT_EN
  logic [1:0] shift_g, shift_z;
`endif

  note_tone_gen #(.WORD_SIZE(8), .CLK_HZ(100000000), .GAP_CYCLES(16), .CNT_W(22)) dut_g (
    .clk(clk), .reset(rst), .note(note_g),
`ifdef NOTE_TONE_GEN_OCTAVE_SHIFT_EN
    .octave_shift(shift_g),
`endif
    .mute(mute_g), .audio_out(audio_g), .playing(play_g),
    .note_change(chg_g), .bad_note(bad_g)
  );

  note_tone_gen #(.WORD_SIZE(8), .CLK_HZ(100000000), .GAP_CYCLES(0), .CNT_W(22)) dut_z (
    .clk(clk), .reset(rst), .note(note_z),
`ifdef NOTE_TONE_GEN_OCTAVE_SHIFT_EN
    .octave_shift(shift_z),
`endif
    .mute(mute_z), .audio_out(audio_z), .playing(play_z),
    .note_change(chg_z), .bad_note(bad_z)
  );

  int n_err = 0;
  int n_chk = 0;
  int exp_q[$];

  typedef struct {
    string      name;
    logic       rst;
    logic [7:0] note;
    logic [3:0] exp;   // {audio, playing, note_change, bad_note}
  } vec_t;
  vec_t vecs[14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  function automatic logic [3:0] obs_g();
    return {audio_g, play_g, chg_g, bad_g};
  endfunction

  function automatic logic [3:0] obs_z();
    return {audio_z, play_z, chg_z, bad_z};
  endfunction

  // Steps until playing rises; n = cycles taken, -1 on timeout; quiet = audio stayed 0.
  task automatic wait_play_g(output int n, output bit quiet);
    bit seen;
    n = 0;
    quiet = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step();
      n++;
      if (play_g === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (audio_g !== 1'b0) quiet = 1'b0;
    end
    if (!seen) n = -1;
  endtask

  // Length of the audio level present at the current sample; -1 on timeout.
  task automatic measure(input bit use_z, output int n);
    logic cur;
    bit   done;
    cur = use_z ? audio_z : audio_g;
    n = 1;
    done = 1'b0;
    for (int i = 0; i < 30000; i++) begin
      step();
      if ((use_z ? audio_z : audio_g) === cur) begin
        n++;
      end else begin
        done = 1'b1;
        break;
      end
    end
    if (!done) n = -1;
  endtask

  task automatic check_level(input string name, input int n);
    int e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: got %0d with no expected level queued", name, n);
    end else begin
      e = exp_q.pop_front();
      check(name, n, e);
    end
  endtask

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1);
  end

  initial begin
    int  n;
    int  cnt;
    bit  quiet;
    bit  ok;

    rst = 1'b1; note_g = 8'h00; note_z = 8'h00; mute_g = 1'b0; mute_z = 1'b0;
`ifdef NOTE_TONE_GEN_OCTAVE_SHIFT_EN
    shift_g = 2'b00; shift_z = 2'b00;
`endif

    vecs[0]  = '{"reset",        1'b1, 8'h4A, 4'b0000};
    vecs[1]  = '{"accept_A4",    1'b0, 8'h4A, 4'b0010};
    vecs[2]  = '{"hold_A4",      1'b0, 8'h4A, 4'b0000};
    vecs[3]  = '{"bad_14",       1'b0, 8'h4E, 4'b0011};
    vecs[4]  = '{"hold_bad_a",   1'b0, 8'h4E, 4'b0000};
    vecs[5]  = '{"hold_bad_b",   1'b0, 8'h4E, 4'b0000};
    vecs[6]  = '{"rest",         1'b0, 8'h00, 4'b0010};
    vecs[7]  = '{"hold_rest",    1'b0, 8'h00, 4'b0000};
    vecs[8]  = '{"bad_upper",    1'b0, 8'h8E, 4'b0011};
    vecs[9]  = '{"upper_ignored",1'b0, 8'h0E, 4'b0000};
    vecs[10] = '{"bad_15",       1'b0, 8'h0F, 4'b0011};
    vecs[11] = '{"bad_13",       1'b0, 8'h0D, 4'b0011};
    vecs[12] = '{"rest_again",   1'b0, 8'h00, 4'b0010};
    vecs[13] = '{"reset_again",  1'b1, 8'h7A, 4'b0000};

    for (int i = 0; i < 14; i++) begin
      rst    = vecs[i].rst;
      note_g = vecs[i].note;
      step();
      check(vecs[i].name, obs_g(), vecs[i].exp);
      if (i == 0) check("reset_z", obs_z(), 4'b0000);
    end

    // A7 accepted on the first edge after reset release, then a 16-cycle gap.
    rst = 1'b0;
    exp_q.push_back(14204);
    exp_q.push_back(14204);
    exp_q.push_back(14204);
    step();
    check("accept_A7", obs_g(), 4'b0010);
    wait_play_g(n, quiet);
    check("gap_len", n, 16);
    check("gap_silent", quiet, 1);
    check("tone_entry", obs_g(), 4'b1100);
    measure(1'b0, n);
    check_level("A7_high", n);
    measure(1'b0, n);
    check_level("A7_low", n);

    // Mute part-way through a high level; the phase must carry on underneath.
    for (int i = 0; i < 49; i++) step();
    check("pre_mute", obs_g(), 4'b1100);
    mute_g = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (audio_g !== 1'b0 || play_g !== 1'b1) ok = 1'b0;
    end
    check("muted", ok, 1);
    mute_g = 1'b0;
    cnt = -1;
    for (int i = 0; i < 30000; i++) begin
      step();
      if (audio_g === 1'b0) begin
        cnt = i + 1;
        break;
      end
    end
    check_level("mute_phase", (cnt < 0) ? -1 : 150 + cnt - 1);

    // Mid-tone change to B7: silent gap, then the new period.
    note_g = 8'h7C;
    exp_q.push_back(12654);
    step();
    check("change_B7", obs_g(), 4'b0010);
    wait_play_g(n, quiet);
    check("gap_len_B7", n, 16);
    check("gap_silent_B7", quiet, 1);
    measure(1'b0, n);
    check_level("B7_high", n);
    note_g = 8'h00;
    step();
    check("to_rest", obs_g(), 4'b0010);

    // Invalid code held: one pulse only, stays silent.
    note_g = 8'h4E;
    step();
    check("bad_once", obs_g(), 4'b0011);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bad_g !== 1'b0 || chg_g !== 1'b0 || audio_g !== 1'b0) cnt++;
    end
    check("bad_hold", cnt, 0);

    // Reset mid-gap and mid-tone.
    note_g = 8'h7A;
    step();
    check("accept_pre_rst", obs_g(), 4'b0010);
    repeat (5) step();
    rst = 1'b1;
    step();
    check("rst_mid_gap", obs_g(), 4'b0000);
    rst = 1'b0;
    step();
    check("redetect", obs_g(), 4'b0010);
    wait_play_g(n, quiet);
    check("gap_len_rst", n, 16);
    repeat (100) step();
    rst = 1'b1;
    note_g = 8'h00;
    step();
    check("rst_mid_tone", obs_g(), 4'b0000);
    rst = 1'b0;
    step();
    check("idle_after_rst", obs_g(), 4'b0000);

    // Zero-gap instance: tone on the accept edge, restart on change.
    note_z = 8'h7C;
    exp_q.push_back(12654);
    step();
    check("z_accept", obs_z(), 4'b1110);
    measure(1'b1, n);
    check_level("z_B7_high", n);
    check("z_low", obs_z(), 4'b0100);
    note_z = 8'h7A;
    step();
    check("z_restart", obs_z(), 4'b1110);
    note_z = 8'h00;
    step();
    check("z_rest", obs_z(), 4'b0010);

`ifdef NOTE_TONE_GEN_OCTAVE_SHIFT_EN
    note_g = 8'h7A;
    step();
    check("sh_accept", obs_g(), 4'b0010);
    wait_play_g(n, quiet);
    check("sh_gap", n, 16);
    shift_g = 2'b01;
    exp_q.push_back(14204);
    step();
    check("sh_plus1_change", obs_g(), 4'b0010);
    wait_play_g(n, quiet);
    check("sh_gap2", n, 16);
    measure(1'b0, n);
    check_level("sh_clamp7_high", n);
    shift_g = 2'b10;
    step();
    check("sh_minus2_change", obs_g(), 4'b0010);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
